// File: rtl/pcie_rx_pkg.sv
// Shared types and helpers for the PCIe VC0 receive credit-return block:
// TLP class, header field positions, credit record and credit arithmetic.
package pcie_rx_pkg;

  typedef enum logic [1:0] {
    CLS_P   = 2'd0,
    CLS_NP  = 2'd1,
    CLS_CPL = 2'd2
  } cls_e;

  localparam int FMT_HI  = 14;
  localparam int FMT_LO  = 13;
  localparam int TYPE_HI = 12;
  localparam int TYPE_LO = 8;
  localparam int LEN_HI  = 9;

  typedef struct packed {
    cls_e       cls;
    logic [8:0] dcred;
  } cred_rec_t;

  localparam int REC_W = $bits(cred_rec_t);

  // One data credit per 4 DW; a zero length field encodes 1024 DW.
  function automatic logic [8:0] calc_dcred(input logic [1:0] fmt, input logic [9:0] length);
    logic [10:0] sum;
    sum = {1'b0, length} + 11'd3;
    if (!fmt[1])
      return 9'd0;
    else if (length == 10'd0)
      return 9'd256;
    else
      return sum[10:2];
  endfunction

  function automatic cred_rec_t classify(input logic [1:0] fmt, input logic [4:0] typ,
                                         input logic [9:0] length);
    cred_rec_t r;
    r.dcred = calc_dcred(fmt, length);
    if (typ[4:3] == 2'b10)
      r.cls = CLS_P;
    else if (typ[4:1] == 4'b0000)
      r.cls = fmt[1] ? CLS_P : CLS_NP;
    else if (typ == 5'b00010 || typ[4:1] == 4'b0010)
      r.cls = CLS_NP;
    else if (typ[4:1] == 4'b0101) begin
      r.cls   = CLS_CPL;
      r.dcred = 9'd0;
    end else begin
      r.cls   = CLS_NP;
      r.dcred = 9'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/pcie_credit_fifo.sv
// Show-ahead synchronous FIFO holding one credit record per received TLP.
module pcie_credit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_en && !empty;
  // A write into a full FIFO is accepted only when a read frees a slot this cycle.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pcie_rx_credit_ret.sv
// VC0 receive credit return: parses TLP headers, queues credit records and
// returns credits on acknowledge. Define PCIE_RX_AUTO_REL_EN to release without acknowledge.
module pcie_rx_credit_ret
  import pcie_rx_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 1
) (
  input  logic                       sys_clk_125,
  input  logic                       rst,
  input  logic [15:0]                rx_data_vc0,
  input  logic                       rx_st_vc0,
  input  logic                       rx_end_vc0,
  input  logic                       tlp_done,
  output logic                       ph_processed_vc0,
  output logic                       pd_processed_vc0,
  output logic [7:0]                 pd_num_vc0,
  output logic                       nph_processed_vc0,
  output logic                       npd_processed_vc0,
  output logic [7:0]                 npd_num_vc0,
  output logic                       ph_buf_status_vc0,
  output logic                       pd_buf_status_vc0,
  output logic                       nph_buf_status_vc0,
  output logic                       npd_buf_status_vc0,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
  output logic                       err_ovf,
  output logic                       err_unf
);
  localparam int              CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   AFULL_TH = CW'(DEPTH - AFULL_MARGIN);

  typedef enum logic [1:0] {P_IDLE, P_HDR1, P_BODY} p_state_e;
  typedef enum logic [1:0] {R_IDLE, R_XFER, R_REM}  r_state_e;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  p_state_e         p_state;
  r_state_e         r_state;
  logic [1:0]       fmt_p0;
  logic [4:0]       typ_p0;
  cred_rec_t        rec_p1;
  logic             vld_p1;
  logic [REC_W-1:0] head_bits;
  cred_rec_t        head;
  logic             fifo_full, fifo_empty, pop, rel_go, rem_p, buf_st;
  cls_e             cur_cls;
  logic             unused_rx;

  assign unused_rx = rx_data_vc0[15];
  assign head      = cred_rec_t'(head_bits);

  // Stage p0: header word0 capture; stage p1: classified record ready to push.
  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      p_state <= P_IDLE;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (rx_st_vc0) begin
        p_state <= P_HDR1;
      end else begin
        case (p_state)
          P_HDR1: begin
            vld_p1  <= 1'b1;
            p_state <= P_BODY;
          end
          P_BODY:  if (rx_end_vc0) p_state <= P_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk_125) begin
    if (rx_st_vc0) begin
      fmt_p0 <= rx_data_vc0[FMT_HI:FMT_LO];
      typ_p0 <= rx_data_vc0[TYPE_HI:TYPE_LO];
    end
    if (p_state == P_HDR1 && !rx_st_vc0)
      rec_p1 <= classify(fmt_p0, typ_p0, rx_data_vc0[LEN_HI:0]);
  end

  pcie_credit_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk     (sys_clk_125),
    .rst     (rst),
    .wr_en   (vld_p1),
    .wr_data (rec_p1),
    .rd_en   (pop),
    .rd_data (head_bits),
    .count   (pend_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop = (r_state == R_IDLE) && rel_go;

`ifdef PCIE_RX_AUTO_REL_EN
  logic unused_done;
  assign unused_done = tlp_done;
  assign rel_go      = !fifo_empty;

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) err_unf <= 1'b0;
    else     err_unf <= 1'b0;
  end
`else
  logic [CW-1:0] done_cnt;
  logic          done_ok;

  // Acknowledges can never outrun the records actually queued.
  assign done_ok = tlp_done && (done_cnt != pend_cnt);
  assign rel_go  = (done_cnt != '0) && !fifo_empty;

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      done_cnt <= '0;
      err_unf  <= 1'b0;
    end else begin
      done_cnt <= done_cnt + CW'(done_ok) - CW'(pop);
      if (tlp_done && !done_ok) err_unf <= 1'b1;
    end
  end
`endif

  // Stage p2: registered credit pulses; 256 data credits split as 255 + 1.
  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      r_state           <= R_IDLE;
      rem_p             <= 1'b0;
      cur_cls           <= CLS_CPL;
      ph_processed_vc0  <= 1'b0;
      pd_processed_vc0  <= 1'b0;
      pd_num_vc0        <= 8'd0;
      nph_processed_vc0 <= 1'b0;
      npd_processed_vc0 <= 1'b0;
      npd_num_vc0       <= 8'd0;
    end else begin
      ph_processed_vc0  <= 1'b0;
      pd_processed_vc0  <= 1'b0;
      pd_num_vc0        <= 8'd0;
      nph_processed_vc0 <= 1'b0;
      npd_processed_vc0 <= 1'b0;
      npd_num_vc0       <= 8'd0;
      case (r_state)
        R_IDLE: if (pop) begin
          r_state <= R_XFER;
          rem_p   <= head.dcred[8];
          cur_cls <= head.cls;
          if (head.cls == CLS_P) begin
            ph_processed_vc0 <= 1'b1;
            pd_processed_vc0 <= |head.dcred;
            pd_num_vc0       <= sat8(head.dcred);
          end else if (head.cls == CLS_NP) begin
            nph_processed_vc0 <= 1'b1;
            npd_processed_vc0 <= |head.dcred;
            npd_num_vc0       <= sat8(head.dcred);
          end
        end
        R_XFER: begin
          if (rem_p) begin
            r_state <= R_REM;
            if (cur_cls == CLS_P) begin
              pd_processed_vc0 <= 1'b1;
              pd_num_vc0       <= 8'd1;
            end else if (cur_cls == CLS_NP) begin
              npd_processed_vc0 <= 1'b1;
              npd_num_vc0       <= 8'd1;
            end
          end else begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_125 or posedge rst) begin
    if (rst) begin
      err_ovf <= 1'b0;
      buf_st  <= 1'b0;
    end else begin
      if (vld_p1 && fifo_full && !pop) err_ovf <= 1'b1;
      buf_st <= (pend_cnt >= AFULL_TH);
    end
  end

  assign ph_buf_status_vc0  = buf_st;
  assign pd_buf_status_vc0  = buf_st;
  assign nph_buf_status_vc0 = buf_st;
  assign npd_buf_status_vc0 = buf_st;

endmodule

// File: tb/tb_pcie_rx_credit_ret.sv
// Directed and randomized bench for pcie_rx_credit_ret, checked against a queue-based credit model.
module tb_pcie_rx_credit_ret;
  localparam int DEPTH = 4;
  localparam int AFM   = 1;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int P = 0, NP = 1, CPL = 2;

  typedef struct { int cls; int dc; } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   rx_data;
  logic          rx_st, rx_end, tlp_done;
  logic          ph_p, pd_p, nph_p, npd_p;
  logic [7:0]    pd_num, npd_num;
  logic          ph_bs, pd_bs, nph_bs, npd_bs;
  logic [CW-1:0] pend_cnt;
  logic          err_ovf, err_unf;

  int   total = 0;
  int   bad   = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  pcie_rx_credit_ret #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .sys_clk_125        (clk),
    .rst                (rst),
    .rx_data_vc0        (rx_data),
    .rx_st_vc0          (rx_st),
    .rx_end_vc0         (rx_end),
    .tlp_done           (tlp_done),
    .ph_processed_vc0   (ph_p),
    .pd_processed_vc0   (pd_p),
    .pd_num_vc0         (pd_num),
    .nph_processed_vc0  (nph_p),
    .npd_processed_vc0  (npd_p),
    .npd_num_vc0        (npd_num),
    .ph_buf_status_vc0  (ph_bs),
    .pd_buf_status_vc0  (pd_bs),
    .nph_buf_status_vc0 (nph_bs),
    .npd_buf_status_vc0 (npd_bs),
    .pend_cnt           (pend_cnt),
    .err_ovf            (err_ovf),
    .err_unf            (err_unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] outs();
    return {ph_p, pd_p, pd_num, nph_p, npd_p, npd_num};
  endfunction

  function automatic logic [3:0] bufs();
    return {ph_bs, pd_bs, nph_bs, npd_bs};
  endfunction

  // Credits from the TLP rules: ceil(DW/4), length 0 meaning 1024 DW.
  function automatic rec_t model_rec(input logic [1:0] fmt, input logic [4:0] typ, input int len);
    rec_t r;
    int   dw;
    dw   = (len == 0) ? 1024 : len;
    r.dc = fmt[1] ? (dw + 3) / 4 : 0;
    if (typ >= 5'b10000 && typ <= 5'b10111)           r.cls = P;
    else if (typ <= 5'b00001)                         r.cls = fmt[1] ? P : NP;
    else if (typ == 5'b00010 || typ == 5'b00100 || typ == 5'b00101) r.cls = NP;
    else if (typ == 5'b01010 || typ == 5'b01011) begin r.cls = CPL; r.dc = 0; end
    else begin r.cls = NP; r.dc = 0; end
    return r;
  endfunction

  function automatic logic [19:0] pulse(input int cls, input logic hdr, input int num);
    logic [9:0] h;
    h = {hdr, (num > 0), 8'(num)};
    if (cls == P)  return {h, 10'd0};
    if (cls == NP) return {10'd0, h};
    return 20'd0;
  endfunction

  task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len);
    rx_st   = 1'b1;
    rx_data = {1'b0, fmt, typ, 8'h00};
    tick();
    rx_st   = 1'b0;
    rx_data = {6'd0, len};
    tick();
    for (int i = 0; i < 4; i++) begin
      rx_data = 16'($urandom);
      rx_end  = (i == 3);
      tick();
    end
    rx_end  = 1'b0;
    rx_data = 16'd0;
    if (q.size() < DEPTH) q.push_back(model_rec(fmt, typ, int'(len)));
  endtask

  task automatic release_one(input string tag);
    rec_t       r;
    logic [19:0] p1, p2;
    r  = q.pop_front();
    p1 = pulse(r.cls, 1'b1, (r.dc > 255) ? 255 : r.dc);
    p2 = (r.dc == 256) ? pulse(r.cls, 1'b0, 1) : 20'd0;
    tlp_done = 1'b1;
    tick();
    tlp_done = 1'b0;
    tick();
    chk({tag, ".pulse1"}, 32'(outs()), 32'(p1));
    tick();
    chk({tag, ".pulse2"}, 32'(outs()), 32'(p2));
    tick();
    chk({tag, ".idle"}, 32'(outs()), 32'd0);
    chk({tag, ".pend"}, 32'(pend_cnt), 32'(q.size()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_st = 1'b0; rx_end = 1'b0; tlp_done = 1'b0; rx_data = 16'd0;
    q.delete();
    tick(); tick();
    chk("rst.outs", 32'(outs()), 32'd0);
    chk("rst.misc", 32'({bufs(), pend_cnt, err_ovf, err_unf}), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [1:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    int         n;

    rst = 1'b1; rx_st = 1'b0; rx_end = 1'b0; tlp_done = 1'b0; rx_data = 16'd0;
    do_reset();

    send_tlp(2'b10, 5'b00000, 10'd16);
    chk("mwr16.pend", 32'(pend_cnt), 32'd1);
    release_one("mwr16");

    send_tlp(2'b00, 5'b00000, 10'd1);
    release_one("mrd");

    send_tlp(2'b10, 5'b00100, 10'd1);
    release_one("cfgwr");

    send_tlp(2'b10, 5'b00000, 10'd0);
    release_one("mwr1024");

    send_tlp(2'b10, 5'b01010, 10'd8);
    chk("cpld.pend", 32'(pend_cnt), 32'd1);
    release_one("cpld");
    chk("cpld.unf0", 32'(err_unf), 32'd0);
    tlp_done = 1'b1;
    tick();
    tlp_done = 1'b0;
    chk("cpld.unf1", 32'(err_unf), 32'd1);
    tick(); tick();
    chk("cpld.nopulse", 32'(outs()), 32'd0);

    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send_tlp(2'b00, 5'b00000, 10'd2);
      chk($sformatf("ovf.pend%0d", i), 32'(pend_cnt), 32'((i > DEPTH) ? DEPTH : i));
      chk($sformatf("ovf.buf%0d", i), 32'(bufs()), (i >= DEPTH - AFM) ? 32'hF : 32'h0);
      chk($sformatf("ovf.err%0d", i), 32'(err_ovf), 32'(i > DEPTH));
    end
    for (int i = 0; i < DEPTH; i++) release_one($sformatf("drain%0d", i));
    tick();
    chk("drain.buf", 32'(bufs()), 32'd0);
    chk("drain.ovf_sticky", 32'(err_ovf), 32'd1);

    rx_st = 1'b1; rx_data = {1'b0, 2'b10, 5'b00000, 8'h00};
    tick();
    rx_st = 1'b0; rx_data = 16'd8;
    tick();
    do_reset();
    tick(); tick();
    chk("midrst.pend", 32'(pend_cnt), 32'd0);

    rx_st = 1'b1; rx_data = {1'b0, 2'b10, 5'b00000, 8'h00};
    tick();
    send_tlp(2'b00, 5'b00000, 10'd1);
    chk("restart.pend", 32'(pend_cnt), 32'd1);
    release_one("restart");

    for (int it = 0; it < 40; it++) begin
      n = int'($urandom_range(1, 3));
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 9))
          0: begin fmt = 2'b10; typ = 5'b00000; end
          1: begin fmt = 2'b11; typ = 5'b00000; end
          2: begin fmt = 2'b00; typ = 5'b00000; end
          3: begin fmt = 2'b01; typ = 5'b00001; end
          4: begin fmt = 2'b10; typ = 5'b00010; end
          5: begin fmt = 2'b00; typ = 5'b00101; end
          6: begin fmt = 2'b01; typ = 5'b10011; end
          7: begin fmt = 2'b11; typ = 5'b10000; end
          8: begin fmt = 2'b10; typ = 5'b01010; end
          default: begin fmt = 2'b10; typ = 5'b11011; end
        endcase
        case ($urandom_range(0, 7))
          0: len = 10'd0;
          1: len = 10'd1;
          2: len = 10'd1021;
          3: len = 10'd1020;
          default: len = 10'($urandom_range(0, 1023));
        endcase
        send_tlp(fmt, typ, len);
      end
      chk($sformatf("rnd%0d.pend", it), 32'(pend_cnt), 32'(q.size()));
      while (q.size() > 0) release_one($sformatf("rnd%0d", it));
    end
    chk("final.errs", 32'({err_ovf, err_unf}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcie_rx_credit_ret.md
Name: pcie_rx_credit_ret

Overview:
User-side receive companion to the x1 PCIe core's VC0 receive path. Parses TLP headers on the 16-bit `rx_*_vc0` stream and classifies each TLP as posted, non-posted or completion. Queues one credit record per TLP and returns header/data credits to the core via `*_processed_vc0` / `*_num_vc0` when the application acknowledges the TLP. Drives the core's `*_buf_status_vc0` inputs from queue occupancy.

Parameters:
- DEPTH, 8: credit-record FIFO entries (power of 2, ≥4).
- AFULL_MARGIN, 1: `buf_status` asserts when occupancy ≥ DEPTH−AFULL_MARGIN.

Ports:
- sys_clk_125  in  1  core user clock
- rst  in  1  asynchronous reset, active-high
- rx_data_vc0  in  16  receive TLP word
- rx_st_vc0  in  1  first word of TLP
- rx_end_vc0  in  1  last word of TLP
- tlp_done  in  1  application consumed oldest outstanding TLP (1-cycle pulse)
- ph_processed_vc0  out  1  posted header credit return pulse
- pd_processed_vc0  out  1  posted data credit return pulse
- pd_num_vc0  out  8  posted data credits returned (valid with pulse, else 0)
- nph_processed_vc0  out  1  non-posted header credit return pulse
- npd_processed_vc0  out  1  non-posted data credit return pulse
- npd_num_vc0  out  8  non-posted data credits returned (valid with pulse, else 0)
- ph_buf_status_vc0, pd_buf_status_vc0, nph_buf_status_vc0, npd_buf_status_vc0  out  1 each  almost-full, all driven identically
- pend_cnt  out  $clog2(DEPTH+1)  records in FIFO
- err_ovf  out  1  sticky: record dropped, FIFO full
- err_unf  out  1  sticky: `tlp_done` with no unacknowledged record

Behaviour:
- Reset: all outputs 0; FIFO empty; both FSMs idle; pending-done counter 0. Reset mid-TLP discards everything. No credits are returned; the core is reset alongside.

Parse FSM (states P_IDLE, P_HDR1, P_BODY):
- P_IDLE + `rx_st_vc0`: capture word0 = fmt[14:13], type[12:8] → P_HDR1.
- P_HDR1: capture length[9:0] from word1. Next cycle push a record {class, hdr, dcred[8:0]} → P_BODY.
- P_BODY + `rx_end_vc0` → P_IDLE.
- `rx_st_vc0` in any non-idle state restarts at P_HDR1. A record already pushed stays; an unfinished header pushes nothing.

Classification (fmt[1] = has data):
- type 10xxx (Msg): posted.
- type 0000x with data (MWr): posted.
- 0000x without data (MRd/MRdLk), 00010 (IO), 0010x (Cfg): non-posted.
- 0101x: completion, no credits returned, but the record is still queued to keep acknowledge ordering.
- Any other type: non-posted header, no data.

Data credits:
- `dcred` = fmt[1] ? (length==0 ? 256 : (length+3)>>2) : 0, 9-bit arithmetic.

Release:
- Each `tlp_done` increments the pending-done counter. If the counter already equals `pend_cnt`, the pulse is ignored and `err_unf` is set.
- Release FSM (R_IDLE, R_XFER, R_REM):
  - R_IDLE: if counter>0 and FIFO non-empty, pop the head and decrement the counter → R_XFER.
  - R_XFER (1 cycle): posted → `ph_processed` = 1, plus `pd_processed` with `pd_num` = min(dcred,255) if dcred>0. Non-posted: same on the np signals. Completion: no pulses.
  - If dcred = 256 → R_REM: one more data pulse, num = 1, no header pulse. Otherwise → R_IDLE.
- Latency: `tlp_done` to first pulse is 2 cycles when the head record is present.
- Push and pop in the same cycle are legal; `pend_cnt` is unchanged.
- Push while full: record dropped, `err_ovf` set. Push is checked after the same-cycle pop.
- `buf_status` outputs are registered from occupancy.

Optional Feature:
- PCIE_RX_AUTO_REL_EN defined: `tlp_done` is ignored and `err_unf` is never set. The pending-done counter is replaced by "FIFO non-empty", so credits are returned 2 cycles after the push.
- Undefined: acknowledge-gated release as above.

Decomposition:
- Package `pcie_rx_pkg`: class enum (CLS_P, CLS_NP, CLS_CPL), fmt/type field constants, record struct {cls, dcred[8:0]}, function `calc_dcred(fmt, length)`.
- Sub-module `pcie_credit_fifo`: synchronous FIFO (DEPTH, record width) with count, full and empty outputs.

Test Plan:
- MWr length=16, then `tlp_done` → 2 cycles later `ph_processed`=1, `pd_processed`=1, `pd_num`=4 for 1 cycle; `pend_cnt` 1→0.
- MRd 3DW, then `tlp_done` → `nph_processed`=1 only; `npd_processed`=0, `npd_num`=0.
- CfgWr0 length=1, then `tlp_done` → `nph_processed`=1, `npd_processed`=1, `npd_num`=1.
- MWr length=0 → pulse 1: `ph_processed`=1, `pd_num`=255; next cycle: `pd_processed`=1, `pd_num`=1, `ph_processed`=0.
- DEPTH=4, AFULL_MARGIN=1, five MRd without `tlp_done` → `buf_status` high from 3rd push; 5th push sets `err_ovf`; `pend_cnt`=4.
- CplD received, then two `tlp_done` pulses → no credit pulses; `pend_cnt` 1→0; second pulse sets `err_unf`.
